// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Drives the 2-bit select of the downstream anode decoder and the active-low
// cathode pattern for whichever digit is currently selected. Display values
// are double-buffered: a load lands in a pending register and is committed to
// the active register only at a frame boundary (sel wrapping 3 -> 0), so a
// digit never tears mid-scan.
//
// Parameters
//   CLK_DIV     clock cycles per digit slot (>= 1)
//   CNT_W       prescaler width, 2**CNT_W >= CLK_DIV
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; 0 freezes prescaler and sel
//   load        single-cycle strobe capturing data_in/dp_in into pending
//   data_in     four hex digits, nibble k shown on digit k (0 = rightmost)
//   dp_in       decimal-point request per digit, 1 = lit
//   blank_lz    1 = blank leading zeros
//   sel         digit select to the anode decoder
//   seg         cathodes {g,f,e,d,c,b,a}, active-low
//   dp          decimal-point cathode, active-low
//   frame_done  one-cycle pulse in the cycle after sel wraps 3 -> 0
//   load_ack    one-cycle pulse when a pending value is committed
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned CNT_W   = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [1:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        load_ack
);

    localparam logic [CNT_W-1:0] PS_LAST = CNT_W'(CLK_DIV - 1);

    // Registered state
    logic [CNT_W-1:0] ps_q,         ps_d;
    logic [1:0]       sel_q,        sel_d;
    logic [15:0]      active_q,     active_d;
    logic [3:0]       active_dp_q,  active_dp_d;
    logic [19:0]      pend_q,       pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             load_ack_q,   load_ack_d;

    // Scan timing
    logic tick;
    logic boundary;

    // Digit decode
    logic [3:0] nib;
    logic [6:0] seg_hex;
    logic       z3, z2, z1;
    logic       blank;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        tick     = en && (ps_q == PS_LAST);
        boundary = tick && (sel_q == 2'd3);

        ps_d = ps_q;
        if (en) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
        end

        sel_d        = tick ? sel_q + 2'd1 : sel_q;
        frame_done_d = boundary;

        active_d     = active_q;
        active_dp_d  = active_dp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        load_ack_d   = 1'b0;

        if (load) begin
            pend_d       = {dp_in, data_in};
            pend_valid_d = 1'b1;
        end

        // A load coinciding with the boundary bypasses the pending buffer and
        // wins over any older pending value, so the newest data is shown.
        if (boundary) begin
            if (load) begin
                {active_dp_d, active_d} = {dp_in, data_in};
                pend_valid_d            = 1'b0;
                load_ack_d              = 1'b1;
            end else if (pend_valid_q) begin
                {active_dp_d, active_d} = pend_q;
                pend_valid_d            = 1'b0;
                load_ack_d              = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q         <= '0;
            sel_q        <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            ps_q         <= ps_d;
            sel_q        <= sel_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            frame_done_q <= frame_done_d;
            load_ack_q   <= load_ack_d;
        end
    end

    // -------------------------------------------------------------------------
    // Digit output: purely combinational from sel_q and active_q
    // -------------------------------------------------------------------------
    always_comb begin
        nib = active_q[{sel_q, 2'b00} +: 4];

        unique case (nib)
            4'h0: seg_hex = 7'b1000000;
            4'h1: seg_hex = 7'b1111001;
            4'h2: seg_hex = 7'b0100100;
            4'h3: seg_hex = 7'b0110000;
            4'h4: seg_hex = 7'b0011001;
            4'h5: seg_hex = 7'b0010010;
            4'h6: seg_hex = 7'b0000010;
            4'h7: seg_hex = 7'b1111000;
            4'h8: seg_hex = 7'b0000000;
            4'h9: seg_hex = 7'b0010000;
            4'hA: seg_hex = 7'b0001000;
            4'hB: seg_hex = 7'b0000011;
            4'hC: seg_hex = 7'b1000110;
            4'hD: seg_hex = 7'b0100001;
            4'hE: seg_hex = 7'b0000110;
            default: seg_hex = 7'b0001110;
        endcase

        // zK: nibbles K..3 are all zero; digit 0 is never a leading zero.
        z3 = (active_q[15:12] == 4'h0);
        z2 = z3 && (active_q[11:8] == 4'h0);
        z1 = z2 && (active_q[7:4] == 4'h0);

        unique case (sel_q)
            2'd0:    blank = 1'b0;
            2'd1:    blank = blank_lz && z1;
            2'd2:    blank = blank_lz && z2;
            default: blank = blank_lz && z3;
        endcase

        seg = blank ? 7'b1111111 : seg_hex;
        dp  = blank ? 1'b1 : ~active_dp_q[sel_q];
    end

    assign sel        = sel_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [1:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        load_ack;

    seg_scan_ctrl #(
        .CLK_DIV(4),
        .CNT_W  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .sel       (sel),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done),
        .load_ack  (load_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpv;
        logic            blz;
        logic [3:0][6:0] segs;   // expected seg per digit, index = digit
        logic [3:0]      dpo;    // expected dp per digit
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Bounded wait for load_ack; an expired bound shows up as a failed check.
    task automatic wait_ack(input string name);
        int k = 0;
        while (load_ack !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ack"}, load_ack, 1);
        chk({name, "_fd"}, frame_done, 1);
    endtask

    task automatic wait_frame(input string name);
        int k = 0;
        while (frame_done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_fd"}, frame_done, 1);
    endtask

    // Called in the cycle right after a boundary (sel=0, prescaler=0).
    task automatic scan_frame(input string name, input logic [3:0][6:0] segs,
                              input logic [3:0] dpo);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            chk({name, "_sel"}, sel, k);
            chk({name, "_seg"}, seg, segs[k]);
            chk({name, "_dp"}, dp, dpo[k]);
        end
    endtask

    initial begin
        int ack_cnt;
        int fd_cnt;

        vecs[0] = '{data:16'h1A3F, dpv:4'b0100, blz:1'b0,
                    segs:{7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, dpo:4'b1011};
        vecs[1] = '{data:16'h4567, dpv:4'b0000, blz:1'b0,
                    segs:{7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}, dpo:4'b1111};
        vecs[2] = '{data:16'h89AB, dpv:4'b1001, blz:1'b1,
                    segs:{7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011}, dpo:4'b0110};
        vecs[3] = '{data:16'hCDEF, dpv:4'b0010, blz:1'b0,
                    segs:{7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}, dpo:4'b1101};
        vecs[4] = '{data:16'h0102, dpv:4'b0000, blz:1'b1,
                    segs:{7'b1111111, 7'b1111001, 7'b1000000, 7'b0100100}, dpo:4'b1111};
        vecs[5] = '{data:16'h0005, dpv:4'b1111, blz:1'b1,
                    segs:{7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, dpo:4'b1110};
        vecs[6] = '{data:16'h0000, dpv:4'b0000, blz:1'b1,
                    segs:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, dpo:4'b1111};

        // Reset state
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        data_in = '0; dp_in = '0; blank_lz = 1'b0;
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_dp", dp, 1);
        chk("rst_fd", frame_done, 0);
        chk("rst_ack", load_ack, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Plain scan: sel steps every 4 cycles, frame_done on the wrap
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            chk("scan_sel", sel, (n / 4) % 4);
            chk("scan_fd", frame_done, (n % 16 == 0) ? 1 : 0);
            chk("scan_seg", seg, 7'b1000000);
            chk("scan_dp", dp, 1);
        end

        // Table-driven loads; first one also verifies the display holds
        for (int i = 0; i < 7; i++) begin
            blank_lz = vecs[i].blz;
            do_load(vecs[i].data, vecs[i].dpv);
            if (i == 0) begin
                chk("hold_sel", sel, 1);
                chk("hold_seg", seg, 7'b1000000);
                chk("hold_ack", load_ack, 0);
            end
            wait_ack("vec");
            scan_frame("vec", vecs[i].segs, vecs[i].dpo);
        end

        // Two loads in one frame: last wins, single ack
        blank_lz = 1'b0;
        wait_frame("dbl_sync");
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        wait_ack("dbl");
        scan_frame("dbl", {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'b1111);
        ack_cnt = 0;
        fd_cnt  = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (load_ack === 1'b1) ack_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
        chk("dbl_extra_ack", ack_cnt, 0);
        chk("dbl_fd_cnt", fd_cnt, 1);

        // Load in the exact boundary cycle commits immediately
        wait_frame("bnd_sync");
        repeat (15) @(negedge clk);
        chk("bnd_pre_sel", sel, 3);
        data_in  = 16'h00C5;
        dp_in    = 4'b0000;
        blank_lz = 1'b1;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_ack", load_ack, 1);
        chk("bnd_fd", frame_done, 1);
        scan_frame("bnd", {7'b1111111, 7'b1111111, 7'b1000110, 7'b0010010}, 4'b1111);

        // Freeze mid-slot with a load during the freeze
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 3) begin
                data_in = 16'h7777;
                dp_in   = 4'b0000;
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
            chk("frz_sel", sel, 3);
            chk("frz_fd", frame_done, 0);
            chk("frz_ack", load_ack, 0);
        end
        load = 1'b0;
        en   = 1'b1;
        @(negedge clk);
        chk("frz_rem_sel", sel, 3);
        chk("frz_rem_fd", frame_done, 0);
        @(negedge clk);
        chk("frz_wrap_sel", sel, 0);
        chk("frz_wrap_fd", frame_done, 1);
        chk("frz_wrap_ack", load_ack, 1);
        chk("frz_wrap_seg", seg, 7'b1111000);

        // Asynchronous reset mid-frame with a pending value
        blank_lz = 1'b0;
        do_load(16'h9999, 4'b0000);
        repeat (4) @(negedge clk);
        chk("pre_rst_sel", sel, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_seg", seg, 7'b1000000);
        chk("arst_dp", dp, 1);
        chk("arst_fd", frame_done, 0);
        chk("arst_ack", load_ack, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        ack_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (load_ack === 1'b1) ack_cnt++;
            chk("post_rst_sel", sel, (n / 4) % 4);
            chk("post_rst_seg", seg, 7'b1000000);
        end
        chk("post_rst_ack", ack_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display. It sits directly upstream of the anode decoder and drives that decoder's 2-bit select. It also produces the active-low cathode pattern for the currently selected digit. New display values are double-buffered and applied only at a frame boundary, so a digit never tears mid-scan.

Parameters:
CLK_DIV, 100000, clock cycles per digit slot (100 MHz gives a 1 kHz digit rate); legal range is 1 or more.
CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= CLK_DIV.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; 0 freezes the prescaler and sel.
load  input  1  single-cycle strobe that captures data_in and dp_in into the pending buffer.
data_in  input  16  four hex digits; nibble k is shown on digit k (k=0 is the rightmost digit).
dp_in  input  4  decimal-point request per digit, 1 = lit.
blank_lz  input  1  1 = blank leading zeros.
sel  output  2  digit select to the anode decoder (0 selects an[0]).
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal-point cathode, active-low.
frame_done  output  1  one-cycle pulse when sel wraps from 3 to 0.
load_ack  output  1  one-cycle pulse when the pending value is committed to the display.

Behaviour:
Reset (asynchronous, rst_n=0):
- prescaler=0, sel=0, active=16'h0000, active_dp=0, pending=0, pend_valid=0, frame_done=0, load_ack=0.
- Resulting outputs: seg=7'b1000000 (digit '0'), dp=1.

Prescaler:
- When en=1, counts 0..CLK_DIV-1 and then wraps to 0.
- tick = en && (prescaler == CLK_DIV-1).
- When en=0, the prescaler and sel hold their values and tick=0.
- With CLK_DIV=1, tick is asserted every enabled cycle.

Select counter:
- On each tick, sel <= sel+1 mod 4.

Frame boundary:
- boundary = tick && sel==3.
- On that edge, sel becomes 0 and frame_done is registered to 1 for exactly that following cycle.

Double buffer:
- load=1: pending <= {dp_in, data_in} and pend_valid <= 1.
- A second load before commit overwrites pending (last write wins). Only one load_ack is issued for that commit.
- On a boundary with pend_valid=1: active <= pending, pend_valid <= 0, and load_ack pulses in the same cycle as frame_done.
- load and boundary in the same cycle: data_in/dp_in commit directly to active, pend_valid <= 0, load_ack pulses.
- Boundary with pend_valid=0: active is unchanged and load_ack stays 0.
- en=0 blocks commits, because no boundary occurs while disabled.

Digit output:
- Combinational from registered sel and active; no extra latency beyond sel.
- nib = active[4*sel+3 : 4*sel].
- seg is the hex decode of nib, active-low. Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- dp = ~active_dp[sel].

Leading-zero blanking:
- Digit k (k>=1) is blanked when blank_lz=1 and nibbles k..3 of active are all zero.
- Digit 0 is never blanked.
- A blanked digit drives seg=7'b1111111 and dp=1, regardless of dp request.

Reset mid-operation:
- All state clears immediately and any pending value is discarded.
- Scanning resumes from sel=0 with prescaler=0 after rst_n deasserts.

Test Plan:
1. CLK_DIV=4, en=1 after reset: sel advances every 4 cycles 0,1,2,3,0. frame_done is high for exactly one cycle, coincident with sel returning to 0. seg=1000000 on every digit.
2. Load data_in=16'h1A3F, dp_in=4'b0100 while sel=1: display is unchanged until the wrap; then load_ack=1 with frame_done. Scan shows digit0 F=0001110, digit1 3=0110000, digit2 A=0001000 with dp=0, digit3 1=1111001.
3. Two loads (16'h1111, then 16'h2222) within one frame: one load_ack at the boundary, and the display shows 2222.
4. load=1 with data 16'h00C5 in the exact boundary cycle: load_ack in that cycle, and the new frame shows 00C5 immediately. With blank_lz=1, digits 3 and 2 show seg=1111111, and digits 1 and 0 show C and 5.
5. Drop en for 10 cycles mid-slot: sel and prescaler hold, and the slot completes its remaining count after en returns. A load during the freeze commits only at the next real wrap.
6. Assert rst_n=0 mid-frame with pend_valid=1: outputs return to reset values asynchronously before the next clock edge. No load_ack occurs afterwards, and the display shows 0000.
